// File: rtl/rv6_bus_pkg.sv
// Shared cache/memory bus definitions: line geometry and the memory-side FSM encoding.
package rv6_bus_pkg;

  localparam int LINE_BITS = 1024;
  localparam int WORD_BITS = 64;
  localparam int BEATS     = 16;
  localparam int OFFS_BITS = 7;
  localparam int BEAT_BITS = $clog2(BEATS);

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RDV  = 2'd2,
    WR   = 2'd3
  } bus_state_e;

  function automatic logic [WORD_BITS-1:0] getWord(input logic [LINE_BITS-1:0] line,
                                                    input logic [BEAT_BITS-1:0] beat);
    return line[int'(beat)*WORD_BITS +: WORD_BITS];
  endfunction

endpackage

// File: rtl/mem_ctrl_wram.sv
// Single-port word RAM backing the memory controller: synchronous write, combinational read.
module wram
  import rv6_bus_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  output logic [WORD_BITS-1:0] rdata_o
);

  logic [WORD_BITS-1:0] mem [2**AW];

  // Contents are deliberately never reset so data survives a controller reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mem_ctrl.sv
// Line-oriented memory controller: serialises 1024-bit cache line fills and
// write-throughs into sixteen 64-bit accesses to a single-port word RAM.
module mem_ctrl
  import rv6_bus_pkg::*;
#(
  parameter int MEM_AW = 13
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [63:0]          b_addr,
  input  logic                 b_rd,
  input  logic                 b_wr,
  input  logic [LINE_BITS-1:0] b_data_in,
  output logic [LINE_BITS-1:0] b_data_out,
  output logic                 b_dv,
  output logic                 b_busy
);

  localparam int LINE_AW = MEM_AW - BEAT_BITS;

  bus_state_e             state_q, state_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic [LINE_AW-1:0]     line_q, line_d;
  logic [LINE_BITS-1:0]   wbuf_q, wbuf_d;
  logic [LINE_BITS-1:0]   rdata_q, rdata_d;

  logic [LINE_AW-1:0]     lineIn;
  logic                   ramWe;
  logic [MEM_AW-1:0]      ramAddr;
  logic [WORD_BITS-1:0]   ramWdata;
  logic [WORD_BITS-1:0]   ramRdata;
  logic                   unusedAddrBits;

  // Address bits above the backing store wrap; the line offset is never used.
  assign lineIn         = b_addr[OFFS_BITS +: LINE_AW];
  assign unusedAddrBits = ^{b_addr[63:OFFS_BITS+LINE_AW], b_addr[OFFS_BITS-1:0]};

  assign ramAddr  = {line_q, beat_q};
  assign ramWdata = getWord(wbuf_q, beat_q);

  wram #(.AW(MEM_AW)) u_wram (
    .clk_i   (clk),
    .we_i    (ramWe),
    .addr_i  (ramAddr),
    .wdata_i (ramWdata),
    .rdata_o (ramRdata)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Write requests win over reads; a write-through may also chain straight off a fill.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    ramWe   = 1'b0;
    case (state_q)
      IDLE: begin
        if (b_wr) begin
          wbuf_d  = b_data_in;
          line_d  = lineIn;
          beat_d  = '0;
          state_d = WR;
        end else if (b_rd) begin
          line_d  = lineIn;
          beat_d  = '0;
          state_d = RD;
        end
      end
      RD: begin
        rdata_d[int'(beat_q)*WORD_BITS +: WORD_BITS] = ramRdata;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = RDV;
        end
      end
      RDV: begin
        if (b_wr) begin
          wbuf_d  = b_data_in;
          line_d  = lineIn;
          beat_d  = '0;
          state_d = WR;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        ramWe  = 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign b_data_out = rdata_q;
  assign b_dv       = (state_q == RDV);
  assign b_busy     = (state_q == RD) || (state_q == WR);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of line writes/reads plus hand-built
// sequences for chaining, priority, ignored requests and mid-transfer reset.
module tb_mem_ctrl;
  import rv6_bus_pkg::*;

  typedef struct {
    logic        isWr;
    logic [63:0] addr;
    logic [63:0] seed;
    int          expCycles;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 clr_n = 1'b0;
  logic [63:0]          b_addr = '0;
  logic                 b_rd = 1'b0;
  logic                 b_wr = 1'b0;
  logic [LINE_BITS-1:0] b_data_in = '0;
  logic [LINE_BITS-1:0] b_data_out;
  logic                 b_dv;
  logic                 b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.MEM_AW(13)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .b_addr     (b_addr),
    .b_rd       (b_rd),
    .b_wr       (b_wr),
    .b_data_in  (b_data_in),
    .b_data_out (b_data_out),
    .b_dv       (b_dv),
    .b_busy     (b_busy)
  );

  function automatic logic [LINE_BITS-1:0] mkLine(input logic [63:0] seed);
    logic [LINE_BITS-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*WORD_BITS +: WORD_BITS] = seed + 64'(k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkLine(input string name, input logic [LINE_BITS-1:0] act,
                           input logic [LINE_BITS-1:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int k = BEATS - 1; k >= 0; k--)
        if (act[k*WORD_BITS +: WORD_BITS] !== exp[k*WORD_BITS +: WORD_BITS]) bad = k;
      $display("[TB] FAIL %s word %0d: got %h expected %h", name, bad,
               act[bad*WORD_BITS +: WORD_BITS], exp[bad*WORD_BITS +: WORD_BITS]);
    end
  endtask

  task automatic waitDv(output int cyc);
    cyc = 0;
    while (b_dv !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic countBusy(output int n, output int dvs);
    n = 0;
    dvs = 0;
    while (b_busy === 1'b1 && n < 40) begin
      if (b_dv === 1'b1) dvs++;
      tick();
      n++;
    end
  endtask

  task automatic doRead(input logic [63:0] addr, output int lat, output logic [LINE_BITS-1:0] line);
    int n;
    b_addr = addr;
    b_rd   = 1'b1;
    tick();
    waitDv(n);
    lat  = n + 1;
    line = b_data_out;
    b_rd = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    int n, dvs, lat;
    logic [LINE_BITS-1:0] line;
    if (v.isWr) begin
      b_addr    = v.addr;
      b_data_in = mkLine(v.seed);
      b_wr      = 1'b1;
      tick();
      b_wr = 1'b0;
      countBusy(n, dvs);
      checkOutput("wrBusyCycles", 64'(n), 64'(v.expCycles));
      checkOutput("wrNoDv", 64'(dvs), 64'd0);
    end else begin
      doRead(v.addr, lat, line);
      checkOutput("rdLatency", 64'(lat), 64'(v.expCycles));
      checkLine("rdData", line, mkLine(v.seed));
      checkOutput("rdIdle", 64'(b_busy), 64'd0);
      checkLine("rdHold", b_data_out, mkLine(v.seed));
    end
  endtask

  initial begin
    vec_t vecs[7];
    int n, dvs, lat;
    logic [LINE_BITS-1:0] line, expMix;

    vecs[0] = '{1'b1, 64'h0000_0080,  64'h1111_0000_0000_0000, 16};
    vecs[1] = '{1'b0, 64'h0000_0080,  64'h1111_0000_0000_0000, 17};
    vecs[2] = '{1'b1, 64'h0001_0000,  64'h2222_0000_0000_0000, 16};
    vecs[3] = '{1'b0, 64'h0000_0000,  64'h2222_0000_0000_0000, 17};
    vecs[4] = '{1'b1, 64'hFFFF_FF80,  64'h3333_0000_0000_0000, 16};
    vecs[5] = '{1'b0, 64'h0000_FFC5,  64'h3333_0000_0000_0000, 17};
    vecs[6] = '{1'b0, 64'h0000_0080,  64'h1111_0000_0000_0000, 17};

    #2;
    checkOutput("rstDv", 64'(b_dv), 64'd0);
    checkOutput("rstBusy", 64'(b_busy), 64'd0);
    checkLine("rstData", b_data_out, '0);
    tick();
    tick();
    clr_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Fill followed by a write-through issued in the data-valid cycle.
    applyStimulus('{1'b1, 64'h100, 64'h4444_0000_0000_0000, 16});
    b_addr = 64'h100;
    b_rd   = 1'b1;
    tick();
    waitDv(n);
    checkOutput("fillLatency", 64'(n + 1), 64'd17);
    checkLine("fillData", b_data_out, mkLine(64'h4444_0000_0000_0000));
    b_rd      = 1'b0;
    b_wr      = 1'b1;
    b_data_in = mkLine(64'h5555_0000_0000_0000);
    tick();
    b_wr = 1'b0;
    countBusy(n, dvs);
    checkOutput("chainBusy", 64'(n), 64'd16);
    checkOutput("chainNoDv", 64'(dvs), 64'd0);
    applyStimulus('{1'b0, 64'h100, 64'h5555_0000_0000_0000, 17});

    // Read and write together in IDLE: write first, then the held read.
    b_addr    = 64'h200;
    b_data_in = mkLine(64'h6666_0000_0000_0000);
    b_rd      = 1'b1;
    b_wr      = 1'b1;
    tick();
    b_wr = 1'b0;
    countBusy(n, dvs);
    checkOutput("prioBusy", 64'(n), 64'd16);
    checkOutput("prioNoDv", 64'(dvs), 64'd0);
    waitDv(n);
    checkOutput("prioRdDelay", 64'(n), 64'd17);
    checkLine("prioData", b_data_out, mkLine(64'h6666_0000_0000_0000));
    b_rd = 1'b0;
    tick();

    // Read request still held after data-valid restarts a read.
    b_addr = 64'h80;
    b_rd   = 1'b1;
    tick();
    waitDv(n);
    checkOutput("b2bLat1", 64'(n + 1), 64'd17);
    tick();
    checkOutput("b2bIdle", 64'(b_busy), 64'd0);
    tick();
    checkOutput("b2bBusy", 64'(b_busy), 64'd1);
    waitDv(n);
    checkOutput("b2bLat2", 64'(n + 1), 64'd17);
    checkLine("b2bData", b_data_out, mkLine(64'h1111_0000_0000_0000));
    b_rd = 1'b0;
    tick();

    // Write pulse during a read is ignored.
    b_addr = 64'h80;
    b_rd   = 1'b1;
    tick();
    repeat (3) tick();
    b_wr      = 1'b1;
    b_data_in = mkLine(64'h7777_0000_0000_0000);
    tick();
    b_wr = 1'b0;
    checkOutput("ignBusy", 64'(b_busy), 64'd1);
    waitDv(n);
    checkOutput("ignLatency", 64'(n + 5), 64'd17);
    checkLine("ignData", b_data_out, mkLine(64'h1111_0000_0000_0000));
    b_rd = 1'b0;
    tick();
    checkOutput("ignNoWr", 64'(b_busy), 64'd0);
    applyStimulus('{1'b0, 64'h80, 64'h1111_0000_0000_0000, 17});

    // Reset in the middle of a read suppresses data-valid.
    b_addr = 64'h80;
    b_rd   = 1'b1;
    tick();
    repeat (5) tick();
    clr_n = 1'b0;
    b_rd  = 1'b0;
    #1;
    checkOutput("rdRstBusy", 64'(b_busy), 64'd0);
    checkLine("rdRstData", b_data_out, '0);
    tick();
    clr_n = 1'b1;
    dvs = 0;
    for (int i = 0; i < 20; i++) begin
      if (b_dv === 1'b1) dvs++;
      tick();
    end
    checkOutput("rdRstNoDv", 64'(dvs), 64'd0);

    // Reset at beat 8 of a write leaves a half-new, half-old line.
    applyStimulus('{1'b1, 64'h300, 64'h8888_0000_0000_0000, 16});
    b_addr    = 64'h300;
    b_data_in = mkLine(64'h9999_0000_0000_0000);
    b_wr      = 1'b1;
    tick();
    b_wr = 1'b0;
    repeat (8) tick();
    clr_n = 1'b0;
    #1;
    checkOutput("wrRstBusy", 64'(b_busy), 64'd0);
    checkOutput("wrRstDv", 64'(b_dv), 64'd0);
    checkLine("wrRstData", b_data_out, '0);
    tick();
    clr_n = 1'b1;
    tick();
    for (int k = 0; k < BEATS; k++)
      expMix[k*WORD_BITS +: WORD_BITS] = (k < 8) ? 64'h9999_0000_0000_0000 + 64'(k)
                                                 : 64'h8888_0000_0000_0000 + 64'(k);
    doRead(64'h300, lat, line);
    checkOutput("wrRstRdLat", 64'(lat), 64'd17);
    checkLine("wrRstRdData", line, expMix);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_AW, default 13, meaning log2 of backing-store depth in 64-bit words (8192 words = 64 KiB).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port clr_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port b_addr  input  64  line address from the cache; bits [6:0] ignored.
REQ-005 SHALL have port b_rd  input  1  line-fill request, held high by the cache until b_dv.
REQ-006 SHALL have port b_wr  input  1  write-through request, sampled for one cycle.
REQ-007 SHALL have port b_data_in  input  1024  line to write, taken from the cache.
REQ-008 SHALL have port b_data_out  output  1024  line read, driven to the cache.
REQ-009 SHALL have port b_dv  output  1  read-data-valid, a one-cycle pulse.
REQ-010 SHALL have port b_busy  output  1  high while in RD or WR.

Function
REQ-011 SHALL implement FSM states IDLE, RD, RDV and WR.
REQ-012 SHALL map line L = b_addr[MEM_AW+2:7] and beat k (0..15) to word index {L,k}; address bits above MEM_AW+2 are ignored, so out-of-range addresses wrap.
REQ-013 In IDLE with b_wr=1, SHALL capture b_data_in and L into a write buffer and go to WR; b_wr has priority over b_rd.
REQ-014 In IDLE with b_rd=1 and b_wr=0, SHALL latch L and go to RD.
REQ-015 In RD, SHALL read one word per cycle, beats 0..15 in order, into b_data_out[64k+63:64k]; it SHALL go to RDV 16 cycles after entry.
REQ-016 In RDV, SHALL drive b_dv=1 for exactly one cycle, with b_data_out complete and stable in that cycle.
REQ-017 In RDV with b_wr=1 in the same cycle, SHALL capture b_data_in and b_addr line and go to WR; otherwise it SHALL go to IDLE.
REQ-018 In WR, SHALL write one word per cycle from the buffer, beats 0..15 in order, and go to IDLE after beat 15.
REQ-019 SHALL NOT assert b_dv for writes.
REQ-020 SHALL ignore b_rd and b_wr while in RD or WR; the requester SHALL keep b_wr low while b_busy=1.
REQ-021 SHALL hold b_data_out unchanged outside RD.
REQ-022 Read latency SHALL be 17 cycles, measured from the b_rd sampling edge to the edge after the b_dv cycle.
REQ-023 A read SHALL return all writes whose WR state completed before the read entered RD.
REQ-024 A b_rd still high in IDLE immediately after RDV SHALL start a new read.
REQ-025 The beat counter SHALL be 4 bits wide and wrap from 15 to 0 when it terminates a state.

Reset
REQ-026 On clr_n=0, SHALL immediately set state=IDLE, beat counter=0, b_dv=0, b_busy=0 and b_data_out=0.
REQ-027 SHALL NOT reset backing-store contents.
REQ-028 Reset during WR SHALL abort the write; beats already written SHALL remain and the rest SHALL be lost.
REQ-029 Reset during RD SHALL abort the read and SHALL NOT produce b_dv.

Structure
REQ-030 SHALL take LINE_BITS=1024, WORD_BITS=64, BEATS=16, OFFS_BITS=7 and the FSM state encoding from the shared bus package, rv6_bus_pkg.
REQ-031 SHALL instantiate exactly one sub-module, wram: a single-port 64-bit RAM of depth 2^MEM_AW with synchronous write and combinational read.
REQ-032 The FSM, beat counter and write buffer SHALL reside in mem_ctrl.

Verification
REQ-033 Write then read: b_wr with b_addr=0x0000_0080 and a line where word k=0x1111_0000_0000_0000+k; after b_busy falls, b_rd at 0x80 -> b_dv after 17 cycles with an identical line.
REQ-034 Fill plus write-through: b_rd at 0x100, then b_wr=1 during the b_dv cycle with new data -> b_busy high 16 cycles; re-read of 0x100 returns the new data.
REQ-035 Simultaneous request in IDLE: b_rd=1 and b_wr=1 -> WR taken first (b_busy for 16 cycles, no b_dv), then RD with b_dv 17 cycles after WR ends.
REQ-036 Wrap-around: with MEM_AW=13, write at 0x1_0000, read at 0x0 -> the same line is returned.
REQ-037 Reset mid-write: clr_n low at beat 8 of WR -> all outputs 0 at once; re-read returns new words 0..7 and old words 8..15.
REQ-038 Ignored request: b_wr pulse while in RD -> no state change, and memory is unchanged.
